// File: rtl/alu_pkg.sv
// Shared types and command encodings for the registered execute-stage ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_RTYPE = 2'd2,
    ALU_RSVD  = 2'd3
  } alu_op_e;

  localparam logic [3:0] CMD_ADD  = 4'h0;
  localparam logic [3:0] CMD_SUB  = 4'h1;
  localparam logic [3:0] CMD_AND  = 4'h2;
  localparam logic [3:0] CMD_OR   = 4'h3;
  localparam logic [3:0] CMD_NOR  = 4'h4;
  localparam logic [3:0] CMD_XOR  = 4'h5;
  localparam logic [3:0] CMD_SLL  = 4'h6;
  localparam logic [3:0] CMD_SLA  = 4'h7;
  localparam logic [3:0] CMD_SRL  = 4'h8;
  localparam logic [3:0] CMD_SRA  = 4'h9;
  localparam logic [3:0] CMD_SLT  = 4'hA;
  localparam logic [3:0] CMD_SLTU = 4'hB;
  localparam logic [3:0] CMD_MUL  = 4'hC;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // The last partial product is folded in combinationally so the result
  // is presented on the same edge the count reaches zero.
  assign done_o    = (cnt_q == CW'(1));
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (abort_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake, iterative multiply and flush.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       alu_op,
  input  logic [3:0]       ex_cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] alu_out_q;
  flags_t           flags_q;

  logic [WIDTH-1:0] res_d;
  flags_t           flags_d;
  logic             is_mul;
  logic             has_flags;
  logic             arith_c;
  logic             arith_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign sum     = {1'b0, in_a} + {1'b0, in_b};
  assign diff    = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
  assign ovf_add = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1]  != in_a[WIDTH-1]);
  assign ovf_sub = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
  assign shamt   = in_b[SHW-1:0];

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;

  always_comb begin
    res_d     = '0;
    arith_c   = 1'b0;
    arith_v   = 1'b0;
    has_flags = 1'b1;
    is_mul    = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_ADD: begin
        res_d   = sum[WIDTH-1:0];
        arith_c = sum[WIDTH];
        arith_v = ovf_add;
      end
      ALU_SUB: begin
        res_d   = diff[WIDTH-1:0];
        arith_c = diff[WIDTH];
        arith_v = ovf_sub;
      end
      ALU_RTYPE: begin
        case (ex_cmd)
          CMD_ADD: begin
            res_d   = sum[WIDTH-1:0];
            arith_c = sum[WIDTH];
            arith_v = ovf_add;
          end
          CMD_SUB: begin
            res_d   = diff[WIDTH-1:0];
            arith_c = diff[WIDTH];
            arith_v = ovf_sub;
          end
          CMD_AND:          res_d = in_a & in_b;
          CMD_OR:           res_d = in_a | in_b;
          CMD_NOR:          res_d = ~(in_a | in_b);
          CMD_XOR:          res_d = in_a ^ in_b;
          CMD_SLL, CMD_SLA: res_d = in_a << shamt;
          CMD_SRL:          res_d = in_a >> shamt;
          CMD_SRA:          res_d = $unsigned($signed(in_a) >>> shamt);
          CMD_SLT:          res_d = WIDTH'($signed(in_a) < $signed(in_b));
          CMD_SLTU:         res_d = WIDTH'(in_a < in_b);
          CMD_MUL:          is_mul = MUL_EN;
          default:          has_flags = 1'b0;
        endcase
      end
      default: has_flags = 1'b0;
    endcase
    flags_d = '0;
    if (has_flags) begin
      flags_d.z = (res_d == '0);
      flags_d.n = res_d[WIDTH-1];
      flags_d.c = arith_c;
      flags_d.v = arith_v;
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort_i   (flush),
    .start_i   (mul_start),
    .a_i       (in_a),
    .b_i       (in_b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_MUL_BUSY;
            end else begin
              alu_out_q   <= res_d;
              flags_q     <= flags_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            state_q     <= ST_IDLE;
            alu_out_q   <= mul_product;
            flags_q     <= '{z: (mul_product == '0), n: mul_product[WIDTH-1], c: 1'b0, v: 1'b0};
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops push expected {result,z,n,c,v}; a monitor checks each transfer.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  alu_op;
  logic [3:0]  ex_cmd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;

  int unsigned total;
  int unsigned bad;
  logic [35:0] sb_q[$];

  alu_pipe #(
    .WIDTH  (32),
    .MUL_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_op    (alu_op),
    .ex_cmd    (ex_cmd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: inputs change only just after posedge, so a negedge sample sees the real transfer condition.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h expected none", {alu_out, flag_z, flag_n, flag_c, flag_v});
      end else begin
        logic [35:0] e;
        e = sb_q.pop_front();
        if ({alu_out, flag_z, flag_n, flag_c, flag_v} !== e) begin
          bad++;
          $display("FAIL result: got %h expected %h", {alu_out, flag_z, flag_n, flag_c, flag_v}, e);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [35:0] exp, input bit push);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    alu_op = op; ex_cmd = cmd; in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
    end else begin
      if (push) sb_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int busy_bad;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; alu_op = 2'd0; ex_cmd = 4'h0;
    total = 0; bad = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    chk("rst_out_flags", {alu_out, flag_z, flag_n, flag_c, flag_v}, 36'd0);
    chk("rst_in_ready", 36'(in_ready), 36'd1);

    issue(2'd1, 4'h0, 32'd5, 32'd5,               {32'h0000_0000, 4'b1010}, 1);
    issue(2'd2, 4'h0, 32'h7FFF_FFFF, 32'd1,       {32'h8000_0000, 4'b0101}, 1);
    issue(2'd2, 4'h9, 32'h8000_0000, 32'h21,      {32'hC000_0000, 4'b0100}, 1);
    issue(2'd0, 4'h0, 32'd3, 32'd4,               {32'd7,         4'b0000}, 1);
    issue(2'd0, 4'h0, 32'hFFFF_FFFF, 32'd1,       {32'h0000_0000, 4'b1010}, 1);
    issue(2'd1, 4'h0, 32'd3, 32'd5,               {32'hFFFF_FFFE, 4'b0100}, 1);
    issue(2'd2, 4'h1, 32'h8000_0000, 32'd1,       {32'h7FFF_FFFF, 4'b0011}, 1);
    issue(2'd2, 4'h2, 32'h0000_F0F0, 32'h0000_FF00, {32'h0000_F000, 4'b0000}, 1);
    issue(2'd2, 4'h3, 32'h0000_00F0, 32'h0000_0F00, {32'h0000_0FF0, 4'b0000}, 1);
    issue(2'd2, 4'h4, 32'd0, 32'd0,               {32'hFFFF_FFFF, 4'b0100}, 1);
    issue(2'd2, 4'h5, 32'h0000_00FF, 32'h0000_000F, {32'h0000_00F0, 4'b0000}, 1);
    issue(2'd2, 4'h6, 32'd1, 32'h24,              {32'h0000_0010, 4'b0000}, 1);
    issue(2'd2, 4'h7, 32'd3, 32'd1,               {32'h0000_0006, 4'b0000}, 1);
    issue(2'd2, 4'h8, 32'h8000_0000, 32'd31,      {32'h0000_0001, 4'b0000}, 1);
    issue(2'd2, 4'hA, 32'hFFFF_FFFF, 32'd1,       {32'h0000_0001, 4'b0000}, 1);
    issue(2'd2, 4'hB, 32'hFFFF_FFFF, 32'd1,       {32'h0000_0000, 4'b1000}, 1);
    issue(2'd2, 4'hD, 32'd9, 32'd9,               {32'h0000_0000, 4'b0000}, 1);
    issue(2'd3, 4'h0, 32'd9, 32'd9,               {32'h0000_0000, 4'b0000}, 1);
    wait_empty();

    issue(2'd2, 4'hC, 32'd7, 32'd6, {32'd42, 4'b0000}, 1);
    n = 0; busy_bad = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_bad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", 36'(n), 36'd32);
    chk("mul_busy_ready", 36'(busy_bad), 36'd0);
    wait_empty();
    issue(2'd2, 4'hC, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFE, 4'b0100}, 1);
    wait_empty();

    out_ready = 1'b0;
    issue(2'd0, 4'h0, 32'd4, 32'd5, {32'd9, 4'b0000}, 1);
    alu_op = 2'd0; ex_cmd = 4'h0; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", 36'(in_ready), 36'd0);
    chk("bp_hold_data", 36'(alu_out), 36'd9);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_hold_valid", {out_valid, alu_out}, {1'b1, 32'd9});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_drain", 36'(in_ready), 36'd1);
    sb_q.push_back({32'd2, 4'b0000});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_overwrite", {out_valid, alu_out}, {1'b1, 32'd2});
    wait_empty();

    issue(2'd2, 4'hC, 32'd3, 32'd3, 36'd0, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    alu_op = 2'd0; in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 36'(in_ready), 36'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 36'(out_valid), 36'd0);
    @(negedge clk);
    chk("flush_ready_back", 36'(in_ready), 36'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_output", 36'(seen), 36'd0);
    issue(2'd0, 4'h0, 32'd1, 32'd2, {32'd3, 4'b0000}, 1);
    wait_empty();

    out_ready = 1'b0;
    issue(2'd2, 4'h0, 32'h7FFF_FFFF, 32'd1, 36'd0, 0);
    chk("held_before_rst", {out_valid, alu_out, flag_z, flag_n, flag_c, flag_v} , {1'b1, 32'h8000_0000, 4'b0101});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_held_clear", {out_valid, alu_out, flag_z, flag_n, flag_c, flag_v}, 37'd0);

    issue(2'd2, 4'hC, 32'd5, 32'd5, 36'd0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mul_ready", 36'(in_ready), 36'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mul_no_output", 36'(seen), 36'd0);

    issue(2'd2, 4'hC, 32'd12, 32'd11, {32'd132, 4'b0000}, 1);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
